// File: rtl/boid_mem_streamer_if.sv
// Bus bundle for boid_mem_streamer: frame control, host init port, display read
// port and the accelerator record/strobe/writeback lanes.
interface boid_mem_streamer_if;
   logic        start;
   logic        busy;
   logic        done;

   logic        host_we;
   logic [5:0]  host_addr;
   logic [31:0] host_x;
   logic [31:0] host_y;
   logic [31:0] host_vx;
   logic [31:0] host_vy;

   logic [5:0]  vga_addr;
   logic [31:0] vga_x;
   logic [31:0] vga_y;

   logic [31:0] x_in_xcel;
   logic [31:0] y_in_xcel;
   logic [31:0] vx_in_xcel;
   logic [31:0] vy_in_xcel;
   logic        r_en_tot;
   logic        r_en_itr;
   logic [6:0]  wb_en;
   logic        acc_clr;

   logic [31:0] x_out_xcel;
   logic [31:0] y_out_xcel;
   logic [31:0] vx_out_xcel;
   logic [31:0] vy_out_xcel;

   modport master (
      output start, host_we, host_addr, host_x, host_y, host_vx, host_vy, vga_addr,
             x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel,
      input  busy, done, vga_x, vga_y, x_in_xcel, y_in_xcel, vx_in_xcel, vy_in_xcel,
             r_en_tot, r_en_itr, wb_en, acc_clr
   );

   modport slave (
      input  start, host_we, host_addr, host_x, host_y, host_vx, host_vy, vga_addr,
             x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel,
      output busy, done, vga_x, vga_y, x_in_xcel, y_in_xcel, vx_in_xcel, vy_in_xcel,
             r_en_tot, r_en_itr, wb_en, acc_clr
   );
endinterface

// File: rtl/boid_mem_streamer.sv
// Boid record store and frame sequencer that streams self/neighbour records to a flocking
// accelerator. Define BOID_DOUBLE_BUFFER_EN for ping-pong banks; default is one in-place bank.
//
// state   | meaning
// IDLE    | waiting for start; host writes accepted
// SELF_RD | read request for self record i
// SELF_LD | self record presented, r_en_tot + acc_clr
// STREAM  | neighbour reads j != i, previous read presented with r_en_itr
// DRAIN   | final neighbour record presented
// WB      | WB_CYCLES writeback window, record i written on the last cycle
// NEXT    | advance i, or pulse done and return to IDLE
module boid_mem_streamer #(
   parameter int NUM_BOIDS = 32,
   parameter int WB_CYCLES = 7
) (
   input  logic               clk,
   input  logic               reset,
   boid_mem_streamer_if.slave bus
);
   localparam int         AW    = $clog2(NUM_BOIDS);
   localparam int         DEPTH = 1 << AW;
   localparam logic [6:0] NB    = 7'(NUM_BOIDS);
   localparam logic [5:0] LAST  = 6'(NUM_BOIDS - 1);
   localparam logic [5:0] STRM_LD = 6'(NUM_BOIDS - 2);
   localparam logic [5:0] WB_LD   = 6'(WB_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SELF_RD = 3'd1;
   localparam logic [2:0] S_SELF_LD = 3'd2;
   localparam logic [2:0] S_STREAM  = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;
   localparam logic [2:0] S_WB      = 3'd5;
   localparam logic [2:0] S_NEXT    = 3'd6;

   logic [2:0]   state;
   logic [5:0]   i;
   logic [5:0]   j;
   logic [5:0]   tmr;
   logic [5:0]   j_next;
   logic [5:0]   wb_k;
   logic [127:0] rd_q;
   logic [63:0]  vga_q;
   logic [127:0] rd_rec;
   logic [63:0]  vga_rec;
   logic [127:0] host_rec;
   logic [127:0] wb_rec;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] vga_idx;
   logic [AW-1:0] host_idx;
   logic [AW-1:0] i_idx;
   logic         host_wr;
   logic         wb_wr;
   logic         vga_ok;
   logic         frame_done;
   logic         present;

   logic [127:0] mem_a [DEPTH];

   assign host_rec   = {bus.host_x, bus.host_y, bus.host_vx, bus.host_vy};
   assign wb_rec     = {bus.x_out_xcel, bus.y_out_xcel, bus.vx_out_xcel, bus.vy_out_xcel};
   assign host_idx   = bus.host_addr[AW-1:0];
   assign vga_idx    = bus.vga_addr[AW-1:0];
   assign i_idx      = i[AW-1:0];
   assign rd_idx     = (state == S_SELF_RD) ? i[AW-1:0] : j[AW-1:0];
   assign host_wr    = bus.host_we && (state == S_IDLE) && ({1'b0, bus.host_addr} < NB);
   assign wb_wr      = (state == S_WB) && (tmr == 6'd0);
   assign vga_ok     = ({1'b0, bus.vga_addr} < NB);
   assign frame_done = (state == S_NEXT) && (i == LAST);
   // the self index is never streamed, so step over it without a bubble
   assign j_next     = (j + 6'd1 == i) ? j + 6'd2 : j + 6'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         i     <= '0;
         j     <= '0;
         tmr   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state <= S_SELF_RD;
                  i     <= '0;
               end
            end
            S_SELF_RD: state <= S_SELF_LD;
            S_SELF_LD: begin
               state <= S_STREAM;
               j     <= (i == 6'd0) ? 6'd1 : 6'd0;
               tmr   <= STRM_LD;
            end
            S_STREAM: begin
               j <= j_next;
               if (tmr == 6'd0) state <= S_DRAIN;
               else             tmr   <= tmr - 6'd1;
            end
            S_DRAIN: begin
               state <= S_WB;
               tmr   <= WB_LD;
            end
            S_WB: begin
               if (tmr == 6'd0) state <= S_NEXT;
               else             tmr   <= tmr - 6'd1;
            end
            S_NEXT: begin
               if (i == LAST) begin
                  state <= S_IDLE;
                  i     <= '0;
               end else begin
                  state <= S_SELF_RD;
                  i     <= i + 6'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BOID_DOUBLE_BUFFER_EN
   logic         bank_sel;
   logic [127:0] mem_b [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           bank_sel <= 1'b0;
      else if (frame_done) bank_sel <= ~bank_sel;
   end

   // host init lands in both banks; writeback always targets the bank not being read
   always_ff @(posedge clk) begin
      if (host_wr)                  mem_a[host_idx] <= host_rec;
      else if (wb_wr && bank_sel)   mem_a[i_idx]    <= wb_rec;
   end

   always_ff @(posedge clk) begin
      if (host_wr)                  mem_b[host_idx] <= host_rec;
      else if (wb_wr && !bank_sel)  mem_b[i_idx]    <= wb_rec;
   end

   assign rd_rec  = bank_sel ? mem_b[rd_idx] : mem_a[rd_idx];
   assign vga_rec = bank_sel ? mem_b[vga_idx][127:64] : mem_a[vga_idx][127:64];
`else
   always_ff @(posedge clk) begin
      if (host_wr)    mem_a[host_idx] <= host_rec;
      else if (wb_wr) mem_a[i_idx]    <= wb_rec;
   end

   assign rd_rec  = mem_a[rd_idx];
   assign vga_rec = mem_a[vga_idx][127:64];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q  <= '0;
         vga_q <= '0;
      end else begin
         rd_q  <= rd_rec;
         vga_q <= vga_ok ? vga_rec : 64'd0;
      end
   end

   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = frame_done;
   assign bus.r_en_tot = (state == S_SELF_LD);
   assign bus.acc_clr  = (state == S_SELF_LD);
   // first STREAM cycle has no returned neighbour yet
   assign bus.r_en_itr = ((state == S_STREAM) && (tmr != STRM_LD)) || (state == S_DRAIN);
   assign present      = bus.r_en_tot || bus.r_en_itr;

   assign bus.x_in_xcel  = present ? rd_q[127:96] : 32'd0;
   assign bus.y_in_xcel  = present ? rd_q[95:64]  : 32'd0;
   assign bus.vx_in_xcel = present ? rd_q[63:32]  : 32'd0;
   assign bus.vy_in_xcel = present ? rd_q[31:0]   : 32'd0;

   assign wb_k       = WB_LD - tmr;
   assign bus.wb_en  = (state == S_WB) ? 7'((8'd2 << wb_k) - 8'd1) : 7'd0;

   assign bus.vga_x  = vga_q[63:32];
   assign bus.vga_y  = vga_q[31:0];
endmodule

// File: doc/boid_mem_streamer.md
BOID_MEM_STREAMER -- requirements
Module: boid_mem_streamer

Interface
REQ-001 SHALL have parameter NUM_BOIDS, default 32, legal range 2..64: number of boid records held.
REQ-002 SHALL have parameter WB_CYCLES, default 7: writeback settle cycles granted to the accelerator.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state registers.
REQ-005 start  in  1  one-cycle pulse; begins one frame update.
REQ-006 busy  out  1  high from the cycle after start is accepted until done.
REQ-007 done  out  1  one-cycle pulse when the frame completes.
REQ-008 host_we, host_addr[5:0], host_x/y/vx/vy[31:0]  in  boid initialisation write port.
REQ-009 vga_addr[5:0] in; vga_x, vga_y[31:0] out  display read port, 1-cycle latency.
REQ-010 x_in_xcel, y_in_xcel, vx_in_xcel, vy_in_xcel  out  32 each  boid record presented to the accelerator.
REQ-011 r_en_tot  out  1  load-self strobe; r_en_itr  out  1  accumulate-neighbour strobe.
REQ-012 wb_en  out  7  writeback thermometer; acc_clr  out  1  accumulator clear pulse.
REQ-013 x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel  in  32 each  updated boid from the accelerator.

Function
REQ-014 Storage SHALL be one 128-bit record per address ({x,y,vx,vy}) with synchronous read, 1-cycle latency.
REQ-015 FSM states SHALL be IDLE, SELF_RD, SELF_LD, STREAM, DRAIN, WB, NEXT. start in IDLE goes to SELF_RD with self index i=0. start in any other state is ignored.
REQ-016 SELF_RD SHALL issue a read of address i. SELF_LD SHALL present the record with r_en_tot=1 and acc_clr=1 for exactly one cycle.
REQ-017 STREAM SHALL issue reads j=0..NUM_BOIDS-1, skipping j==i. Each returned record SHALL be presented one cycle later with r_en_itr=1, giving exactly NUM_BOIDS-1 r_en_itr cycles per self boid.
REQ-018 DRAIN SHALL last one cycle and present the final streamed record with r_en_itr=1. r_en_itr SHALL be 0 in every other state.
REQ-019 WB SHALL last WB_CYCLES cycles. On cycle k (0-based) wb_en SHALL equal bits [k:0] set. On the last cycle, x/y/vx/vy_out_xcel SHALL be written to address i of the write bank.
REQ-020 NEXT SHALL increment i. When i was NUM_BOIDS-1, it SHALL pulse done, drop busy and return to IDLE; otherwise it SHALL go to SELF_RD.
REQ-021 Per-boid latency SHALL be NUM_BOIDS+WB_CYCLES+3 cycles; frame latency = NUM_BOIDS*(NUM_BOIDS+WB_CYCLES+3) cycles from the cycle after start to done.
REQ-022 x/y/vx/vy_in_xcel SHALL be driven to 0 whenever neither r_en_tot nor r_en_itr is high.
REQ-023 A host write SHALL be accepted only in IDLE, writing both banks when compiled with double buffering. host_we while busy SHALL be dropped with no state change.
REQ-024 host_addr/vga_addr >= NUM_BOIDS: writes SHALL be dropped; reads SHALL return 0.
REQ-025 When host_we and start are asserted in the same IDLE cycle, the write SHALL complete and start SHALL be accepted. The frame SHALL see the written record.

Reset
REQ-026 Reset SHALL force IDLE, i=0, bank select 0. Outputs SHALL be busy=0, done=0, r_en_tot=0, r_en_itr=0, acc_clr=0, wb_en=0, xcel data outputs=0, vga outputs=0.
REQ-027 Reset mid-frame SHALL abort without a further memory write. Record contents SHALL NOT be cleared.

Configuration
REQ-028 Macro BOID_DOUBLE_BUFFER_EN defined: two banks. Reads come from the current bank, writeback goes to the other bank, and bank select toggles in the cycle done pulses. vga reads the current bank, so the display never sees a partial frame.
REQ-029 Macro BOID_DOUBLE_BUFFER_EN undefined: one bank, in-place writeback. Later self boids see already-updated earlier boids. vga reads the single bank.

Verification
REQ-030 NUM_BOIDS=4, start -> done exactly 4*(4+7+3)=56 cycles after the cycle following start; busy high throughout.
REQ-031 Self i=2 -> r_en_itr high 3 cycles, presenting records 0,1,3 in order; record 2 presented only with r_en_tot.
REQ-032 Accelerator model returns x_out=x_in+0x10000 -> after a frame every x has advanced by 0x10000. With BOID_DOUBLE_BUFFER_EN, vga_x is unchanged until the done cycle, then reflects the new values.
REQ-033 host_we to addr 1 with x=0x00640000 while busy -> dropped; the same write in IDLE -> vga_x at addr 1 reads 0x00640000 next cycle.
REQ-034 Assert reset in the middle of WB for i=1 -> all outputs 0 immediately, record 1 unchanged, and a following start runs a full 56-cycle frame.
REQ-035 start re-pulsed at cycle 10 of a frame -> ignored; a single done pulse only.
